dmem_access_ctrl: RTL and testbench

DMEM_ACCESS_CTRL -- requirements
Module: dmem_access_ctrl

---
 rtl/dmem_access_ctrl_pkg.sv | 16 +
 rtl/dmem_access_ctrl_wait_counter.sv | 36 +++
 rtl/dmem_access_ctrl.sv | 135 +++++++++++++
 tb/tb_dmem_access_ctrl.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_access_ctrl_pkg.sv
// Shared CPU constants for the data-memory access controller: state encodings
// and default sizing.
package dmem_access_ctrl_pkg;

  localparam int unsigned DEFAULT_DATA_W  = 8;
  localparam int unsigned DEFAULT_TIMEOUT = 15;
  localparam int unsigned CNT_W           = 8;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'b00,
    ST_RD_WAIT = 2'b01,
    ST_WR_WAIT = 2'b10,
    ST_DONE    = 2'b11
  } state_e;

endpackage

// File: rtl/dmem_access_ctrl_wait_counter.sv
// Per-access wait-cycle counter. tc_c_o flags the cycle whose increment
// would reach TERMINAL.
module wait_counter #(
  parameter int unsigned CNT_W    = 8,
  parameter int unsigned TERMINAL = 15
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clear_i,
  input  logic en_i,
  output logic tc_c_o
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clear_i) begin
      cnt_d = '0;
    end else if (en_i) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tc_c_o = (cnt_q == CNT_W'(TERMINAL - 1));

endmodule

// File: rtl/dmem_access_ctrl.sv
// Data-memory access controller: latches a CPU load/store, strobes memory
// until ready or timeout, and stalls the CPU via busywait meanwhile.
module dmem_access_ctrl
  import dmem_access_ctrl_pkg::*;
#(
  parameter int unsigned DATA_W  = DEFAULT_DATA_W,
  parameter int unsigned TIMEOUT = DEFAULT_TIMEOUT
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              cpu_read,
  input  logic              cpu_write,
  input  logic [DATA_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              busywait,
  output logic              mem_read,
  output logic              mem_write,
  output logic [DATA_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ready,
  output logic [1:0]        err
);

  state_e state_q;
  state_e state_d;

  logic [DATA_W-1:0] cpu_rdata_q, cpu_rdata_d;
  logic [DATA_W-1:0] mem_addr_q,  mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
  logic              mem_read_q,  mem_read_d;
  logic              mem_write_q, mem_write_d;
  logic [1:0]        err_q,       err_d;

  logic launch_c;
  logic in_wait_c;
  logic timeout_c;
  logic cnt_clear_c;
  logic cnt_en_c;
  logic tc_c;

  assign launch_c  = (state_q == ST_IDLE) && (cpu_read || cpu_write);
  assign in_wait_c = (state_q == ST_RD_WAIT) || (state_q == ST_WR_WAIT);
  // mem_ready has priority over the timeout in the same cycle
  assign timeout_c = in_wait_c && !mem_ready && tc_c;

  wait_counter #(
    .CNT_W    (CNT_W),
    .TERMINAL (TIMEOUT)
  ) u_wait_counter (
    .clk_i   (CLK),
    .rst_i   (RESET),
    .clear_i (cnt_clear_c),
    .en_i    (cnt_en_c),
    .tc_c_o  (tc_c)
  );

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (cpu_write) begin
          state_d = ST_WR_WAIT;
        end else if (cpu_read) begin
          state_d = ST_RD_WAIT;
        end
      end
      ST_RD_WAIT, ST_WR_WAIT: begin
        if (mem_ready || tc_c) begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    busywait    = launch_c || in_wait_c;
    cnt_clear_c = launch_c;
    cnt_en_c    = in_wait_c && !mem_ready;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    cpu_rdata_d = cpu_rdata_q;
    mem_read_d  = (state_d == ST_RD_WAIT);
    mem_write_d = (state_d == ST_WR_WAIT);
    err_d       = err_q | {launch_c && cpu_read && cpu_write, timeout_c};
    if (launch_c) begin
      mem_addr_d  = cpu_addr;
      mem_wdata_d = cpu_wdata;
    end
    if (state_q == ST_RD_WAIT) begin
      if (mem_ready) begin
        cpu_rdata_d = mem_rdata;
      end else if (timeout_c) begin
        cpu_rdata_d = '0;
      end
    end
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      cpu_rdata_q <= '0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_read_q  <= 1'b0;
      mem_write_q <= 1'b0;
      err_q       <= 2'b00;
    end else begin
      cpu_rdata_q <= cpu_rdata_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      mem_read_q  <= mem_read_d;
      mem_write_q <= mem_write_d;
      err_q       <= err_d;
    end
  end

  assign cpu_rdata = cpu_rdata_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign mem_read  = mem_read_q;
  assign mem_write = mem_write_q;
  assign err       = err_q;

endmodule

// File: tb/tb_dmem_access_ctrl.sv
// Scoreboard bench for dmem_access_ctrl: a bench-side memory answers each
// access after a chosen number of wait cycles; expectations queue at launch.
module tb_dmem_access_ctrl;

  localparam int unsigned DW = 8;
  localparam int unsigned TO = 15;

  logic          CLK = 1'b0;
  logic          RESET;
  logic          cpu_read, cpu_write;
  logic [DW-1:0] cpu_addr, cpu_wdata, cpu_rdata;
  logic          busywait, mem_read, mem_write;
  logic [DW-1:0] mem_addr, mem_wdata, mem_rdata;
  logic          mem_ready;
  logic [1:0]    err;

  dmem_access_ctrl #(.DATA_W(DW), .TIMEOUT(TO)) dut (
    .CLK(CLK), .RESET(RESET),
    .cpu_read(cpu_read), .cpu_write(cpu_write),
    .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata),
    .busywait(busywait), .mem_read(mem_read), .mem_write(mem_write),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .mem_ready(mem_ready), .err(err)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic [DW-1:0] rdata;
    int            strobes;
    logic [1:0]    err;
  } exp_t;

  exp_t          sb[$];
  int            checks = 0;
  int            failures = 0;
  logic [DW-1:0] rdata_hold = '0;
  logic [1:0]    err_exp = 2'b00;

  // One CPU access; ready_at = wait cycle carrying mem_ready (0 = never)
  task automatic do_access(input string nm, input bit rd, input bit wr,
                           input logic [DW-1:0] addr, input logic [DW-1:0] wdata,
                           input logic [DW-1:0] rdata, input int ready_at,
                           input bit hold);
    exp_t e, got;
    int strobes, edges;
    bit done, ok;
    ok = (ready_at >= 1) && (ready_at <= int'(TO));
    e.strobes = ok ? ready_at : int'(TO);
    e.rdata = wr ? rdata_hold : (ok ? rdata : 8'h00);
    rdata_hold = e.rdata;
    if (rd && wr) err_exp[1] = 1'b1;
    if (!ok) err_exp[0] = 1'b1;
    e.err = err_exp;
    sb.push_back(e);

    @(negedge CLK);
    cpu_read = rd; cpu_write = wr; cpu_addr = addr; cpu_wdata = wdata; mem_ready = 1'b0;
    #1;
    checks++;
    if (busywait !== 1'b1) begin
      failures++; $display("FAIL %s busy_idle_req got=%b exp=1", nm, busywait);
    end
    strobes = 0; edges = 0; done = 0;
    while (!done && edges < 40) begin
      @(posedge CLK); #1; edges++;
      if (mem_read || mem_write) begin
        strobes++;
        checks++;
        if (mem_write !== wr || mem_read !== !wr || busywait !== 1'b1) begin
          failures++;
          $display("FAIL %s strobe rd=%b wr=%b busy=%b exp rd=%b wr=%b busy=1",
                   nm, mem_read, mem_write, busywait, !wr, wr);
        end
        if (strobes == 1) begin
          checks++;
          if (mem_addr !== addr || mem_wdata !== wdata) begin
            failures++;
            $display("FAIL %s latch addr=%h wdata=%h exp %h %h", nm, mem_addr, mem_wdata, addr, wdata);
          end
        end
        if (strobes == ready_at) begin
          mem_ready = 1'b1; mem_rdata = rdata;
        end else begin
          mem_ready = 1'b0; mem_rdata = DW'($urandom);
        end
      end else begin
        done = 1;
      end
    end
    got = sb.pop_front();
    checks++;
    if (!done) begin
      failures++; $display("FAIL %s bound got=no_done exp=done", nm);
    end
    checks++;
    if (strobes !== got.strobes || edges !== got.strobes + 1) begin
      failures++;
      $display("FAIL %s latency strobes=%0d edges=%0d exp %0d %0d", nm, strobes, edges,
               got.strobes, got.strobes + 1);
    end
    checks++;
    if (busywait !== 1'b0 || cpu_rdata !== got.rdata || err !== got.err) begin
      failures++;
      $display("FAIL %s done busy=%b rdata=%h err=%b exp busy=0 rdata=%h err=%b",
               nm, busywait, cpu_rdata, err, got.rdata, got.err);
    end
    if (hold) begin
      mem_ready = 1'b1; mem_rdata = 8'hFF;
      @(posedge CLK); #1;
    end
    cpu_read = 1'b0; cpu_write = 1'b0;
    for (int i = 0; i < (hold ? 4 : 1); i++) begin
      @(posedge CLK); #1;
      checks++;
      if (mem_read !== 1'b0 || mem_write !== 1'b0 || cpu_rdata !== got.rdata || busywait !== 1'b0) begin
        failures++;
        $display("FAIL %s idle_after rd=%b wr=%b rdata=%h busy=%b exp 0 0 %h 0",
                 nm, mem_read, mem_write, cpu_rdata, busywait, got.rdata);
      end
    end
    mem_ready = 1'b0;
  endtask

  task automatic apply_reset();
    @(negedge CLK);
    RESET = 1'b1;
    #2;
    RESET = 1'b0;
    rdata_hold = '0;
    err_exp = 2'b00;
  endtask

  task automatic test_reset();
    cpu_read = 0; cpu_write = 0; cpu_addr = 0; cpu_wdata = 0; mem_rdata = 0; mem_ready = 0;
    RESET = 1'b1;
    #12;
    checks++;
    if (cpu_rdata !== 0 || mem_addr !== 0 || mem_wdata !== 0 || mem_read !== 0 ||
        mem_write !== 0 || err !== 0 || busywait !== 0) begin
      failures++;
      $display("FAIL reset_vals rdata=%h addr=%h wdata=%h rd=%b wr=%b err=%b busy=%b exp all 0",
               cpu_rdata, mem_addr, mem_wdata, mem_read, mem_write, err, busywait);
    end
    cpu_read = 1'b1; #1;
    checks++;
    if (busywait !== 1'b1) begin
      failures++; $display("FAIL reset_busy got=%b exp=1", busywait);
    end
    @(posedge CLK); #1;
    checks++;
    if (mem_read !== 1'b0) begin
      failures++; $display("FAIL reset_hold_strobe got=%b exp=0", mem_read);
    end
    cpu_read = 1'b0;
    @(negedge CLK); RESET = 1'b0;
  endtask

  task automatic test_reset_mid();
    @(negedge CLK);
    cpu_read = 1'b1; cpu_addr = 8'h44; mem_ready = 1'b0;
    repeat (3) @(posedge CLK);
    #3;
    RESET = 1'b1;
    #1;
    checks++;
    if (mem_read !== 1'b0 || mem_write !== 1'b0 || mem_addr !== 0 || cpu_rdata !== 0 ||
        err !== 0 || busywait !== 1'b1) begin
      failures++;
      $display("FAIL reset_mid rd=%b wr=%b addr=%h rdata=%h err=%b busy=%b exp 0 0 00 00 00 1",
               mem_read, mem_write, mem_addr, cpu_rdata, err, busywait);
    end
    cpu_read = 1'b0;
    @(negedge CLK); RESET = 1'b0;
    rdata_hold = '0; err_exp = 2'b00;
    do_access("reset_mid_next", 1, 0, 8'h45, 8'h00, 8'h5A, 1, 0);
  endtask

  task automatic test_read();
    do_access("read_a5", 1, 0, 8'h20, 8'h00, 8'hA5, 2, 0);
  endtask

  task automatic test_write();
    do_access("write_10", 0, 1, 8'h10, 8'h3C, 8'h77, 1, 0);
  endtask

  task automatic test_ready_at_timeout();
    do_access("ready_at_to", 1, 0, 8'h30, 8'h00, 8'hC3, int'(TO), 0);
  endtask

  task automatic test_timeout();
    do_access("timeout_rd", 1, 0, 8'h31, 8'h00, 8'h99, 0, 0);
  endtask

  task automatic test_conflict();
    do_access("conflict", 1, 1, 8'h55, 8'hAA, 8'h12, 1, 0);
  endtask

  task automatic test_hold_done();
    do_access("hold_done", 1, 0, 8'h66, 8'h00, 8'h3E, 1, 1);
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 8; i++) begin
      do_access("b2b", (i % 3) != 1, (i % 3) == 1, DW'($urandom), DW'($urandom),
                DW'($urandom), int'($urandom_range(1, 4)), 0);
    end
  endtask

  initial begin
    test_reset();
    test_read();
    test_write();
    test_ready_at_timeout();
    test_back_to_back();
    test_hold_done();
    test_conflict();
    test_reset_mid();
    test_timeout();
    apply_reset();
    test_read();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
